div10_share_scheduler: RTL and testbench

Time-multiplexes one iterative divide-by-10 / modulo-10 engine among several clock counters (seconds, minutes, hours, day) that each need a 6-bit binary value split into BCD tens and ones for the 7-segment decoders. The block runs a round-robin arbiter, a req/ack handshake per requester and a small FSM. The FSM sequences repeated subtract-10 steps, one per clock, then returns tens/ones to the granted requester. It sits between the counter bank and the display mux.

---
 rtl/div10_share_scheduler.sv | 149 ++++++++++++++
 tb/tb_div10_share_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/div10_share_scheduler.sv
// div10_share_scheduler
//
// Shares one iterative divide-by-10 / modulo-10 engine among up to four
// clock counters. A round-robin arbiter picks a requester, the FSM subtracts
// 10 once per clock until the remainder drops below 10, and the BCD tens/ones
// pair is returned with a one-cycle ack pulse to the winner.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   req         per-requester request level, held until ack
//   value_flat  requester i value in bits [6i+5:6i]
//   ack         one-hot, one-cycle pulse marking a valid result
//   tens        quotient of the last completed conversion
//   ones        remainder of the last completed conversion
//   grant_id    index of the requester currently or last served
//   busy        high whenever the FSM is not idle
module div10_share_scheduler #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [6*NREQ-1:0] value_flat,
  output logic [NREQ-1:0]   ack,
  output logic [3:0]        tens,
  output logic [3:0]        ones,
  output logic [1:0]        grant_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [5:0]      rem_q, rem_d;
  logic [3:0]      q_q, q_d;
  logic [1:0]      grant_id_q, grant_id_d;
  logic [1:0]      last_grant_q, last_grant_d;
  logic [3:0]      tens_q, tens_d;
  logic [3:0]      ones_q, ones_d;
  logic [NREQ-1:0] ack_q, ack_d;

  logic            win_valid;
  logic [1:0]      win_id;
  logic [1:0]      scan_idx;
  logic [5:0]      win_value;

  // Round-robin scan starting one past the last served requester, wrapping.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = 2'((int'(last_grant_q) + k) % NREQ);
      if (!win_valid && req[scan_idx]) begin
        win_valid = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  // Constant-index mux keeps the value select free of variable part-selects.
  always_comb begin
    win_value = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == 2'(i)) begin
        win_value = value_flat[6*i +: 6];
      end
    end
  end

  // Next-state logic; subtraction is guarded by the compare so rem never
  // underflows and q tops out at 6 for an input of 63.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    q_d          = q_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    tens_d       = tens_q;
    ones_d       = ones_q;
    ack_d        = ack_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          rem_d      = win_value;
          q_d        = '0;
          grant_id_d = win_id;
          state_d    = SUB;
        end
      end
      SUB: begin
        if (rem_q >= 6'd10) begin
          rem_d = rem_q - 6'd10;
          q_d   = q_q + 4'd1;
        end else begin
          tens_d       = q_q;
          ones_d       = rem_q[3:0];
          ack_d        = {{(NREQ-1){1'b0}}, 1'b1} << grant_id_q;
          last_grant_d = grant_id_q;
          state_d      = DONE;
        end
      end
      DONE: begin
        ack_d   = '0;
        state_d = IDLE;
      end
      default: begin
        ack_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Reset discards any in-flight conversion; last_grant starts at NREQ-1 so
  // requester 0 has top priority after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      q_q          <= '0;
      grant_id_q   <= '0;
      last_grant_q <= 2'(NREQ - 1);
      tens_q       <= '0;
      ones_q       <= '0;
      ack_q        <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      q_q          <= q_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
      ack_q        <= ack_d;
    end
  end

  assign ack      = ack_q;
  assign tens     = tens_q;
  assign ones     = ones_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_div10_share_scheduler.sv
// Testbench for div10_share_scheduler: directed requests with hand-computed
// BCD results pushed into a scoreboard queue; a monitor pops and compares on
// every ack pulse.
module tb_div10_share_scheduler;

  localparam int NREQ = 4;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [6*NREQ-1:0] valueFlat;
  logic [NREQ-1:0]   ack;
  logic [3:0]        tens;
  logic [3:0]        ones;
  logic [1:0]        grantId;
  logic              busy;

  typedef struct {
    int id;
    int tens;
    int ones;
  } expect_t;

  expect_t sbQ[$];
  int      checks = 0;
  int      errors = 0;

  div10_share_scheduler #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .value_flat (valueFlat),
    .ack        (ack),
    .tens       (tens),
    .ones       (ones),
    .grant_id   (grantId),
    .busy       (busy)
  );

  // 10 ns clock; the bench drives and samples on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Every ack pulse must match the oldest outstanding expected result.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      if (ack != '0) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_ack", int'(ack), 0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("ack_onehot", int'(ack), 1 << e.id);
          checkOutput("grant_id", int'(grantId), e.id);
          checkOutput("tens", int'(tens), e.tens);
          checkOutput("ones", int'(ones), e.ones);
        end
      end
    end
  end

  task automatic pushExpect(input int id, input int t, input int o);
    expect_t e;
    e.id   = id;
    e.tens = t;
    e.ones = o;
    sbQ.push_back(e);
  endtask

  // Single request: raise req[id] at a falling edge, optionally change the
  // value one cycle after the grant, check ack latency (q+2 falling edges
  // after raising), pulse width and busy drop.
  task automatic applyStimulus(input int id, input int value, input int t, input int o,
                               input int expLatency, input int newValue);
    int cnt;
    @(negedge clk);
    valueFlat[6*id +: 6] = 6'(value);
    req[id] = 1'b1;
    pushExpect(id, t, o);
    cnt = 0;
    while (cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1 && newValue >= 0) valueFlat[6*id +: 6] = 6'(newValue);
      if (ack != '0) break;
    end
    checkOutput("ack_latency", cnt, expLatency);
    checkOutput("busy_in_done", int'(busy), 1);
    req[id] = 1'b0;
    @(negedge clk);
    checkOutput("ack_width", int'(ack), 0);
    checkOutput("busy_after", int'(busy), 0);
  endtask

  // Raise every requester in mask at once and drop each as its ack arrives.
  task automatic runBatch(input logic [NREQ-1:0] mask);
    logic [NREQ-1:0] pending;
    int cnt;
    @(negedge clk);
    pending = mask;
    req     = req | mask;
    cnt     = 0;
    while (pending != '0 && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if ((ack & pending) != '0) begin
        req     = req & ~ack;
        pending = pending & ~ack;
      end
    end
    checkOutput("batch_done", int'(pending), 0);
    req = '0;
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    valueFlat = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_ack", int'(ack), 0);
    checkOutput("reset_tens", int'(tens), 0);
    checkOutput("reset_ones", int'(ones), 0);
    checkOutput("reset_grant", int'(grantId), 0);
    checkOutput("reset_busy", int'(busy), 0);

    // All four from reset: served 0,1,2,3, then again 0,1,2,3.
    valueFlat = {6'd63, 6'd42, 6'd17, 6'd5};
    pushExpect(0, 0, 5);
    pushExpect(1, 1, 7);
    pushExpect(2, 4, 2);
    pushExpect(3, 6, 3);
    runBatch(4'b1111);
    valueFlat = {6'd19, 6'd51, 6'd8, 6'd30};
    pushExpect(0, 3, 0);
    pushExpect(1, 0, 8);
    pushExpect(2, 5, 1);
    pushExpect(3, 1, 9);
    runBatch(4'b1111);

    // Single request on req[1] with 47.
    applyStimulus(1, 47, 4, 7, 6, -1);

    // Boundary values on req[0].
    applyStimulus(0, 0, 0, 0, 2, -1);
    applyStimulus(0, 9, 0, 9, 2, -1);
    applyStimulus(0, 10, 1, 0, 3, -1);
    applyStimulus(0, 59, 5, 9, 7, -1);
    applyStimulus(0, 63, 6, 3, 8, -1);

    // Make last_grant=2, then req[2] and req[3] together: 3 before 2.
    applyStimulus(2, 20, 2, 0, 4, -1);
    valueFlat[6*3 +: 6] = 6'd33;
    valueFlat[6*2 +: 6] = 6'd14;
    pushExpect(3, 3, 3);
    pushExpect(2, 1, 4);
    runBatch(4'b1100);

    // Value changes after the grant are ignored.
    applyStimulus(0, 38, 3, 8, 5, 12);

    // Reset mid-SUB with 55 after two subtractions; no ack may follow.
    @(negedge clk);
    valueFlat[5:0] = 6'd55;
    req[0] = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("busy_mid_sub", int'(busy), 1);
    rst    = 1'b1;
    req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_sub_ack", int'(ack), 0);
    checkOutput("rst_sub_tens", int'(tens), 0);
    checkOutput("rst_sub_ones", int'(ones), 0);
    checkOutput("rst_sub_busy", int'(busy), 0);
    repeat (10) @(negedge clk);
    applyStimulus(1, 23, 2, 3, 4, -1);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", sbQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
